// File: rtl/ram_bus_controller.sv
// Bus master for an asynchronous 8-bit SRAM: address setup, write pulse or output enable, read capture.
// All outputs are registered and derived from the next state, so strobes change cleanly on one edge.
module ram_bus_controller #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_ack,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_writeNEn,
  output logic [DATA_WIDTH-1:0] o_writeData,
  output logic                  o_dataOe,
  output logic                  o_noe,
  input  logic [DATA_WIDTH-1:0] i_readData
);

  typedef enum logic [2:0] {IDLE, SETUP, WPULSE, WHOLD, RSTROBE, DONE} state_t;

  localparam logic [3:0] LAST = 4'(STROBE_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wne_q, wne_d;
  logic                  noe_q, noe_d;
  logic                  doe_q, doe_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      wne_q   <= 1'b1;
      noe_q   <= 1'b1;
      doe_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      wne_q   <= wne_d;
      noe_q   <= noe_d;
      doe_q   <= doe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          addr_d  = i_addr;
          we_d    = i_we;
          wdat_d  = i_wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = we_q ? WPULSE : RSTROBE;
      end
      WPULSE: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = WHOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WHOLD: state_d = DONE;
      RSTROBE: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          rdata_d = i_readData;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered strobes follow the state being entered, so each one is exact to the cycle.
    wne_d  = (state_d != WPULSE);
    noe_d  = (state_d != RSTROBE);
    doe_d  = we_d && (state_d == SETUP || state_d == WPULSE || state_d == WHOLD);
    ack_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  assign o_busy      = busy_q;
  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_address   = addr_q;
  assign o_writeNEn  = wne_q;
  assign o_writeData = wdat_q;
  assign o_dataOe    = doe_q;
  assign o_noe       = noe_q;

  a_oe_vs_drive: assert property (@(posedge i_clk) disable iff (i_rst) !(!noe_q && doe_q));
  a_we_vs_oe:    assert property (@(posedge i_clk) disable iff (i_rst) !(!wne_q && !noe_q));
  a_addr_hold:   assert property (@(posedge i_clk) disable iff (i_rst)
                   ($changed(addr_q) || $changed(wdat_q)) |-> ($past(state_q) == IDLE));

endmodule

// File: tb/tb_ram_bus_controller.sv
// Bench for ram_bus_controller: directed tests at STROBE_CYCLES=2, random sweeps at 1 and 15.
module tb_ram_bus_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       we;
    logic [7:0] data;
  } exp_t;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 15;

    logic       rst, req, we, busy, ack, wne, doe, noe;
    logic [7:0] addr, wdata, rdata, address, wdat, rdat;
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    exp_t       sb [$];
    exp_t       mon_e;
    int         ovl = 0;
    int         wr_cnt = 0;
    bit         fin = 1'b0;
    logic [63:0] tr_wlow, tr_doe, tr_noe, tr_ack;
    int         tr_addr_bad, tr_lat;
    logic       rw;
    logic [7:0] ra, rd;

    ram_bus_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STROBE_CYCLES(S)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
      .o_busy(busy), .o_ack(ack), .o_rdata(rdata), .o_address(address),
      .o_writeNEn(wne), .o_writeData(wdat), .o_dataOe(doe), .o_noe(noe),
      .i_readData(rdat)
    );

    // SRAM model: latches on the rising edge of the write strobe, drives data while OE is low.
    assign rdat = noe ? 8'h00 : mem[address];
    always @(posedge wne) begin
      if (doe) begin
        mem[address] = wdat;
        wr_cnt++;
      end
    end

    always @(negedge clk) begin
      if (!rst && ((!noe && doe) || (!wne && !noe))) ovl++;
      if (ack) begin
        if (sb.size() == 0) begin
          check("spurious_ack", 32'(ack), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          if (!mon_e.we) check("rdata", 32'(rdata), 32'(mon_e.data));
        end
      end
    end

    task automatic init_env();
      for (int i = 0; i < 256; i++) begin
        mem[i]     = 8'(i) ^ 8'h5C;
        ref_mem[i] = 8'(i) ^ 8'h5C;
      end
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #1 check("reset_state", 32'({busy, ack, wne, noe, doe, address, wdat, rdata}), 32'h0600_0000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    endtask

    // One transaction; traces strobes per cycle (cycle 0 = acceptance cycle) through one cycle past ack.
    task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d, input logic toggle);
      sb.push_back('{we: w, data: (w ? d : ref_mem[a])});
      if (w) ref_mem[a] = d;
      tr_wlow = '0; tr_doe = '0; tr_noe = '0; tr_ack = '0;
      tr_addr_bad = 0; tr_lat = 0;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      for (int k = 0; k < 48; k++) begin
        if (k > 0) begin
          @(posedge clk);
          @(negedge clk);
        end
        if (k == 1) req = 1'b0;
        if (toggle && k >= 1) begin
          addr  = 8'($urandom);
          wdata = 8'($urandom);
        end
        tr_wlow[k] = ~wne;
        tr_doe[k]  = doe;
        tr_noe[k]  = ~noe;
        tr_ack[k]  = ack;
        if (k >= 1 && address != a) tr_addr_bad++;
        if (tr_lat != 0) break;
        if (ack) tr_lat = k;
      end
      check("ack_seen", 32'(tr_lat != 0), 32'd1);
    endtask

    task automatic finish_block();
      check("strobe_overlap", 32'(ovl), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);
      fin = 1'b1;
    endtask

    if (g == 0) begin : dir
      initial begin
        int n, w0;
        init_env();

        txn(1'b1, 8'h3C, 8'hA5, 1'b0);
        check("wr_lat", 32'(tr_lat), 32'd5);
        check("wr_wne_low", tr_wlow[31:0], 32'h0000_000C);
        check("wr_doe", tr_doe[31:0], 32'h0000_001E);
        check("wr_ack", tr_ack[31:0], 32'h0000_0020);
        check("wr_ram", 32'(mem[8'h3C]), 32'hA5);

        txn(1'b0, 8'h3C, 8'h00, 1'b0);
        check("rd_lat", 32'(tr_lat), 32'd4);
        check("rd_noe_low", tr_noe[31:0], 32'h0000_000C);
        check("rd_ack", tr_ack[31:0], 32'h0000_0010);
        check("rd_doe", tr_doe[31:0], 32'h0);
        check("rd_hold", 32'(rdata), 32'hA5);

        // Back-to-back with req held through DONE.
        sb.push_back('{we: 1'b1, data: 8'hFF});
        ref_mem[0] = 8'hFF;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'h00; wdata = 8'hFF;
        n = 0;
        while (!ack && n < 40) begin @(posedge clk); @(negedge clk); n++; end
        check("b2b_wr_lat", 32'(n), 32'd5);
        we = 1'b0;
        sb.push_back('{we: 1'b0, data: 8'hFF});
        @(posedge clk); @(negedge clk);
        check("b2b_idle_gap", 32'(busy), 32'd0);
        @(posedge clk); @(negedge clk);
        check("b2b_accept", 32'(busy), 32'd1);
        req = 1'b0;
        n = 0;
        while (!ack && n < 40) begin @(posedge clk); @(negedge clk); n++; end
        check("b2b_rd_lat", 32'(n), 32'd3);
        @(posedge clk); @(negedge clk);
        check("b2b_ack_pulse", 32'(ack), 32'd0);

        // Input bus toggling mid-write.
        w0 = wr_cnt;
        txn(1'b1, 8'h10, 8'h5A, 1'b1);
        check("tog_addr_stable", 32'(tr_addr_bad), 32'd0);
        check("tog_ram", 32'(mem[8'h10]), 32'h5A);
        check("tog_wr_count", 32'(wr_cnt - w0), 32'd1);

        // Reset mid write pulse.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'h77; wdata = 8'h11;
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pre_rst_wne", 32'(wne), 32'd0);
        rst = 1'b1;
        #1 check("rst_async", 32'({wne, busy, ack, doe}), 32'h8);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 8'h99, 8'h00, 1'b0);
        check("post_rst_rd", 32'(rdata), 32'hC5);

        txn(1'b1, 8'hFF, 8'h3E, 1'b0);
        txn(1'b0, 8'hFF, 8'h00, 1'b0);
        check("addr_ff_rd", 32'(rdata), 32'h3E);
        finish_block();
      end
    end else begin : swp
      initial begin
        init_env();
        for (int n = 0; n < 40; n++) begin
          rw = 1'($urandom);
          ra = {($urandom_range(0, 1) != 0) ? 4'hF : 4'h0, 4'($urandom_range(0, 15))};
          rd = 8'($urandom);
          txn(rw, ra, rd, 1'b0);
          check("sweep_lat", 32'(tr_lat), rw ? 32'(3 + S) : 32'(2 + S));
        end
        finish_block();
      end
    end
  end

  initial begin
    int t = 0;
    while (!(u[0].fin && u[1].fin && u[2].fin) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check("all_blocks_done", 32'(u[0].fin && u[1].fin && u[2].fin), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bus_controller.md
Name: ram_bus_controller

Overview:
- Synchronous bus master for the asynchronous 8-bit SRAM and its tri-state read buffer: the initiating end of the RAM interface.
- Accepts single read/write requests from the core through a req/ack handshake.
- Sequences address setup, an active-low write pulse or active-low output enable, and data sampling with guaranteed non-overlapping strobes.
- Sits between the CPU datapath and the RAM/transmitter pair.

Parameters:
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 8, RAM data width
- STROBE_CYCLES, 2, clock cycles the write pulse or output enable is held active; legal range 1..15

Ports:
- i_clk  input  1  system clock, all state changes on the rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_req  input  1  core request; sampled only in IDLE
- i_we  input  1  1 = write, 0 = read; sampled with i_req
- i_addr  input  ADDR_WIDTH  request address
- i_wdata  input  DATA_WIDTH  write data
- o_busy  output  1  high whenever state is not IDLE
- o_ack  output  1  one-cycle completion pulse
- o_rdata  output  DATA_WIDTH  read result; valid from the o_ack cycle until the next read completes
- o_address  output  ADDR_WIDTH  RAM address
- o_writeNEn  output  1  RAM write enable, active low
- o_writeData  output  DATA_WIDTH  data toward RAM
- o_dataOe  output  1  high enables this block's write-data driver onto the RAM data bus
- o_noe  output  1  RAM read transmitter enable, active low
- i_readData  input  DATA_WIDTH  data from RAM transmitter

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state IDLE, strobe counter 0
  - o_writeNEn=1, o_noe=1, o_dataOe=0
  - o_ack=0, o_busy=0
  - o_address=0, o_writeData=0, o_rdata=0
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SETUP, WPULSE, WHOLD, RSTROBE, DONE.
- IDLE:
  - If i_req=1, latch i_addr, i_we and i_wdata into o_address, an internal we flag and o_writeData, then go to SETUP.
  - If i_req=0, stay in IDLE.
- SETUP (1 cycle):
  - Address is stable; both strobes are inactive.
  - Write: o_dataOe=1, next state WPULSE.
  - Read: o_dataOe=0, next state RSTROBE.
- WPULSE (STROBE_CYCLES cycles): o_writeNEn=0 and o_dataOe=1. Counter counts to STROBE_CYCLES-1, then go to WHOLD.
- WHOLD (1 cycle): o_writeNEn=1; o_dataOe, address and data are held. Next state DONE.
- RSTROBE (STROBE_CYCLES cycles):
  - o_noe=0.
  - On the last cycle's clock edge, capture i_readData into o_rdata and set o_noe=1 at the same edge.
  - Next state DONE.
- DONE (1 cycle): o_ack=1, all strobes inactive, o_dataOe=0. Next state IDLE.
- Latency, with cycle 0 being the IDLE cycle where i_req is sampled high:
  - write: o_ack in cycle 3+STROBE_CYCLES
  - read: o_ack in cycle 2+STROBE_CYCLES
- Throughput: i_req held high in the DONE cycle is not accepted. The next acceptance is in the IDLE cycle after DONE, i.e. at most one transaction per (latency+1) cycles.
- Invariants, checked by assertion:
  - o_noe=0 and o_dataOe=1 never coincide.
  - o_writeNEn=0 and o_noe=0 never coincide.
  - o_address and o_writeData only change in the IDLE to SETUP transition.
- i_req, i_we, i_addr and i_wdata are ignored while busy. Changing them mid-transaction has no effect.
- Address wraps naturally; 0xFF is a legal address and no arithmetic is performed on it.
- Reset asserted during WPULSE releases o_writeNEn asynchronously. The aborted write is undefined in RAM, and no ack is issued.

Test Plan:
- Write, STROBE_CYCLES=2: req with we=1, addr=0x3C, wdata=0xA5.
  - o_writeNEn is low for exactly cycles 2-3.
  - o_dataOe is high for cycles 1-4.
  - o_ack is high in cycle 5 only.
  - The RAM model holds 0xA5 at 0x3C.
- Read back 0x3C: o_noe is low for cycles 2-3, o_ack is high in cycle 4, and o_rdata=0xA5 from cycle 4 on.
- Back-to-back with i_req held high: write 0xFF@0x00, then read 0x00.
  - The second request is accepted only in the IDLE cycle after DONE.
  - The read returns 0xFF.
  - Exactly one ack is issued per transaction.
- Bus-change test: toggle i_addr and i_wdata every cycle during a write to 0x10 with data 0x5A. The RAM receives 0x5A at 0x10 only, and o_address stays 0x10 throughout.
- Reset test: assert i_rst mid-WPULSE.
  - o_writeNEn=1, o_busy=0 and o_ack=0 in the same cycle, before any clock edge.
  - After release, a read of an untouched address returns the RAM model's initial value.
- Sweep STROBE_CYCLES=1 and 15 with random read/write traffic.
  - Latencies match the formulas.
  - The strobe-overlap assertions never fire.
  - A scoreboard against a RAM model passes.
